oai33_exhaustive_bist: RTL and testbench

//  Stimulus generator and response compactor for a 6-input OAI33 cell under test.

---
 rtl/oai33_exhaustive_bist.sv | 123 ++++++++++++
 tb/tb_oai33_exhaustive_bist.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oai33_exhaustive_bist.sv
// Exhaustive BIST for a 6-input OAI33 cell: walks all 64 input vectors and compacts ZN into a 16-bit MISR.
// Optional macro OAI33_BIST_COMPARE_EN adds an internal golden model and the ERR_CNT output.
module oai33_exhaustive_bist #(
  parameter int          HOLD    = 2,
  parameter logic [15:0] SEED    = 16'hFFFF,
  parameter logic [15:0] EXP_SIG = 16'h0000
) (
  input  logic        CLK,
  input  logic        RN,
  input  logic        START,
  input  logic        ZN,
  output logic        A1,
  output logic        A2,
  output logic        A3,
  output logic        B1,
  output logic        B2,
  output logic        B3,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic [15:0] SIG,
  output logic [1:0]  dbg_state
`ifdef OAI33_BIST_COMPARE_EN
  ,
  output logic [6:0]  ERR_CNT
`endif
);

  // Handshake: START is a one-cycle request accepted only when BUSY=0; DONE/PASS/SIG
  // form the response and stay stable until the next accepted START or reset.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

  state_t      state;
  logic [5:0]  vec;
  logic [7:0]  hold_cnt;
  logic        sample;
  logic        fb;
  logic [15:0] sig_next;
  logic        pass_next;

  assign {B3, B2, B1, A3, A2, A1} = vec;
  assign dbg_state = state;
  assign sample    = (hold_cnt == HOLD_LAST);

  always_comb begin
    fb       = SIG[15] ^ ZN;
    sig_next = {SIG[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  end

`ifdef OAI33_BIST_COMPARE_EN
  logic       golden;
  logic [6:0] err_next;

  always_comb begin
    golden    = ~((|vec[2:0]) & (|vec[5:3]));
    err_next  = ERR_CNT + {6'd0, (ZN != golden)};
    pass_next = (sig_next == EXP_SIG) && (err_next == 7'd0);
  end
`else
  always_comb begin
    pass_next = (sig_next == EXP_SIG);
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state    <= ST_IDLE;
      vec      <= 6'd0;
      hold_cnt <= 8'd0;
      SIG      <= SEED;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      PASS     <= 1'b0;
`ifdef OAI33_BIST_COMPARE_EN
      ERR_CNT  <= 7'd0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            state    <= ST_RUN;
            vec      <= 6'd0;
            hold_cnt <= 8'd0;
            SIG      <= SEED;
            BUSY     <= 1'b1;
            DONE     <= 1'b0;
            PASS     <= 1'b0;
`ifdef OAI33_BIST_COMPARE_EN
            ERR_CNT  <= 7'd0;
`endif
          end
        end
        ST_RUN: begin
          if (!sample) begin
            hold_cnt <= hold_cnt + 8'd1;
          end else begin
            // Sample edge: ZN has settled for HOLD cycles on the current vector.
            SIG      <= sig_next;
            hold_cnt <= 8'd0;
            vec      <= vec + 6'd1;
`ifdef OAI33_BIST_COMPARE_EN
            ERR_CNT  <= err_next;
`endif
            if (vec == 6'd63) begin
              state <= ST_DONE;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
              PASS  <= pass_next;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oai33_exhaustive_bist.sv
// Randomized scoreboard bench for oai33_exhaustive_bist: one HOLD=2 and one HOLD=1 instance,
// each driven by a behavioural cell model with selectable fault modes.
module tb_oai33_exhaustive_bist;

  // ---------------- reference model ----------------
  // mode 0: correct cell, 1: ZN stuck 0, 2: ZN stuck 1, 3: inverted at vec 27, 4: inverted at 5 and 40
  function automatic logic ref_zn(input int mode, input logic [5:0] v);
    logic g;
    g = !((v[2:0] != 3'd0) && (v[5:3] != 3'd0));
    case (mode)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return g ^ (v == 6'd27);
      4:       return g ^ ((v == 6'd5) || (v == 6'd40));
      default: return g;
    endcase
  endfunction

  function automatic logic [15:0] ref_sig(input int mode);
    logic [15:0] s;
    logic        b;
    s = 16'hFFFF;
    for (int i = 0; i < 64; i++) begin
      b = s[15] ^ ref_zn(mode, 6'(i));
      s = {s[14:0], 1'b0} ^ (b ? 16'h1021 : 16'h0000);
    end
    return s;
  endfunction

  function automatic int ref_err(input int mode);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++)
      if (ref_zn(mode, 6'(i)) != ref_zn(0, 6'(i))) n++;
    return n;
  endfunction

  localparam logic [15:0] GOLD_SIG = ref_sig(0);

  function automatic logic [23:0] model_entry(input int mode);
    logic [15:0] s;
    int          e;
    logic        p;
    s = ref_sig(mode);
    e = ref_err(mode);
`ifdef OAI33_BIST_COMPARE_EN
    p = (s == GOLD_SIG) && (e == 0);
`else
    p = (s == GOLD_SIG);
`endif
    return {7'(e), p, s};
  endfunction

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  logic rn = 1'b0;
  always #5 clk = ~clk;

  logic start2 = 1'b0, start1 = 1'b0;
  int   mode2 = 0, mode1 = 0;
  logic a1_2, a2_2, a3_2, b1_2, b2_2, b3_2, busy2, done2, pass2;
  logic a1_1, a2_1, a3_1, b1_1, b2_1, b3_1, busy1, done1, pass1;
  logic [15:0] sig2, sig1;
  logic [1:0]  st2, st1;
  logic [5:0]  stim2, stim1;
  logic        zn2, zn1;
`ifdef OAI33_BIST_COMPARE_EN
  logic [6:0] err2, err1;
`endif

  assign stim2 = {b3_2, b2_2, b1_2, a3_2, a2_2, a1_2};
  assign stim1 = {b3_1, b2_1, b1_1, a3_1, a2_1, a1_1};
  assign zn2   = ref_zn(mode2, stim2);
  assign zn1   = ref_zn(mode1, stim1);

  oai33_exhaustive_bist #(.HOLD(2), .SEED(16'hFFFF), .EXP_SIG(GOLD_SIG)) u_h2 (
    .CLK(clk), .RN(rn), .START(start2), .ZN(zn2),
    .A1(a1_2), .A2(a2_2), .A3(a3_2), .B1(b1_2), .B2(b2_2), .B3(b3_2),
    .BUSY(busy2), .DONE(done2), .PASS(pass2), .SIG(sig2), .dbg_state(st2)
`ifdef OAI33_BIST_COMPARE_EN
    , .ERR_CNT(err2)
`endif
  );

  oai33_exhaustive_bist #(.HOLD(1), .SEED(16'hFFFF), .EXP_SIG(GOLD_SIG)) u_h1 (
    .CLK(clk), .RN(rn), .START(start1), .ZN(zn1),
    .A1(a1_1), .A2(a2_1), .A3(a3_1), .B1(b1_1), .B2(b2_1), .B3(b3_1),
    .BUSY(busy1), .DONE(done1), .PASS(pass1), .SIG(sig1), .dbg_state(st1)
`ifdef OAI33_BIST_COMPARE_EN
    , .ERR_CNT(err1)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [23:0] exp_q2[$];
  logic [23:0] exp_q1[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_done(input string tag, input logic [23:0] e, input logic [15:0] s,
                            input logic p, input logic [6:0] ec, input int bc, input int hold,
                            input logic walk_bad, input logic [5:0] stim);
    chk({tag, "_sig"}, 32'(s), 32'(e[15:0]));
    chk({tag, "_pass"}, 32'(p), 32'(e[16]));
    chk({tag, "_sig_known"}, 32'($isunknown(s)), 32'd0);
`ifdef OAI33_BIST_COMPARE_EN
    chk({tag, "_err_cnt"}, 32'(ec), 32'(e[23:17]));
`else
    if (ec != 7'd0) chk({tag, "_err_tie"}, 32'(ec), 32'd0);
`endif
    chk({tag, "_busy_len"}, 32'(bc), 32'(64 * hold));
    chk({tag, "_walk"}, 32'(walk_bad), 32'd0);
    chk({tag, "_stim_zero"}, 32'(stim), 32'd0);
  endtask

  // ---------------- monitors ----------------
  int   bc2 = 0, bc1 = 0;
  logic wb2 = 1'b0, wb1 = 1'b0;
  logic dq2 = 1'b0, dq1 = 1'b0;
  logic [23:0] e2, e1;

  always @(negedge clk) begin
    if (busy2) begin
      if (stim2 != 6'(bc2 / 2)) wb2 = 1'b1;
      bc2++;
    end
    if (done2 && !dq2) begin
      if (exp_q2.size() == 0) chk("h2_unexpected_done", 32'd1, 32'd0);
      else begin
        e2 = exp_q2.pop_front();
`ifdef OAI33_BIST_COMPARE_EN
        check_done("h2", e2, sig2, pass2, err2, bc2, 2, wb2, stim2);
`else
        check_done("h2", e2, sig2, pass2, 7'd0, bc2, 2, wb2, stim2);
`endif
      end
      bc2 = 0; wb2 = 1'b0;
    end else if (!busy2 && !done2) begin
      bc2 = 0; wb2 = 1'b0;
    end
    dq2 = done2;
  end

  always @(negedge clk) begin
    if (busy1) begin
      if (stim1 != 6'(bc1)) wb1 = 1'b1;
      bc1++;
    end
    if (done1 && !dq1) begin
      if (exp_q1.size() == 0) chk("h1_unexpected_done", 32'd1, 32'd0);
      else begin
        e1 = exp_q1.pop_front();
`ifdef OAI33_BIST_COMPARE_EN
        check_done("h1", e1, sig1, pass1, err1, bc1, 1, wb1, stim1);
`else
        check_done("h1", e1, sig1, pass1, 7'd0, bc1, 1, wb1, stim1);
`endif
      end
      bc1 = 0; wb1 = 1'b0;
    end else if (!busy1 && !done1) begin
      bc1 = 0; wb1 = 1'b0;
    end
    dq1 = done1;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic run2(input int mode, input bit push);
    tick(1);
    mode2 = mode;
    start2 = 1'b1;
    if (push) exp_q2.push_back(model_entry(mode));
    tick(1);
    start2 = 1'b0;
  endtask

  task automatic run1(input int mode);
    tick(1);
    mode1 = mode;
    start1 = 1'b1;
    exp_q1.push_back(model_entry(mode));
    tick(1);
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int which, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((which == 2) ? done2 : done1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
    tick(1);
  endtask

  task automatic check_idle(input string nm, input logic [5:0] stim, input logic b,
                            input logic d, input logic p, input logic [15:0] s,
                            input logic [1:0] st);
    chk({nm, "_stim"}, 32'(stim), 32'd0);
    chk({nm, "_bdp"}, 32'({b, d, p}), 32'd0);
    chk({nm, "_sig"}, 32'(s), 32'hFFFF);
    chk({nm, "_state"}, 32'(st), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rn = 1'b0;
    start2 = 1'b1;  // START during reset must lose
    tick(2);
    rn = 1'b1;
    start2 = 1'b0;
    check_idle("rst_h2", stim2, busy2, done2, pass2, sig2, st2);
    check_idle("rst_h1", stim1, busy1, done1, pass1, sig1, st1);
`ifdef OAI33_BIST_COMPARE_EN
    chk("rst_err_h2", 32'(err2), 32'd0);
`endif

    // correct cell, then stuck-at faults
    run2(0, 1'b1);
    chk("start_busy", 32'({busy2, done2}), 32'b10);
    wait_done(2, "h2_good");
    run2(1, 1'b1); wait_done(2, "h2_zn0");
    run2(2, 1'b1); wait_done(2, "h2_zn1");

    // abort at run cycle 40, then a full run
    run2(0, 1'b0);
    tick(38);
    rn = 1'b0;
    tick(1);
    rn = 1'b1;
    check_idle("abort", stim2, busy2, done2, pass2, sig2, st2);
    run2(0, 1'b1); wait_done(2, "h2_after_abort");

    // ignored STARTs mid-run, then restart from DONE
    run2(4, 1'b1);
    tick(8);  start2 = 1'b1; tick(1); start2 = 1'b0;
    tick(49); start2 = 1'b1; tick(1); start2 = 1'b0;
    wait_done(2, "h2_ignored_start");
    run2(0, 1'b1);
    chk("restart_clear", 32'({busy2, done2, pass2}), 32'b100);
    wait_done(2, "h2_restart");

    // HOLD=1: single-vector fault and correct cell
    run1(3); wait_done(1, "h1_fault27");
    run1(0); wait_done(1, "h1_good");

    // randomized runs with random gaps and modes
    for (int k = 0; k < 6; k++) begin
      tick($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 0) begin
        run2(int'($urandom_range(0, 4)), 1'b1); wait_done(2, "h2_rand");
      end else begin
        run1(int'($urandom_range(0, 4))); wait_done(1, "h1_rand");
      end
    end

    tick(3);
    chk("q2_drained", 32'(exp_q2.size()), 32'd0);
    chk("q1_drained", 32'(exp_q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
